// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its dump engine.
package regfile_pkg;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_DUMP,
    DS_DONE,
    DS_HOLD
  } dump_state_e;

  // Address width needed to index n registers.
  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump sequencer: detects the halted rising edge, walks every register index over a
// valid/ready handshake, pulses done after the last accepted beat, then waits for the
// core to leave halt before it can be retriggered.
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = addr_w(NREGS)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          halted,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [AW-1:0] dump_idx,
  output logic          dump_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_e   state_q;
  logic          halted_q;
  logic [AW-1:0] idx_q;
  logic          valid_q;
  logic          done_q;

  // Dump state machine with registered valid/done; idx returns to 0 whenever not dumping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= DS_IDLE;
      halted_q <= 1'b0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      halted_q <= halted;
      done_q   <= 1'b0;
      unique case (state_q)
        DS_IDLE: begin
          if (halted && !halted_q) begin
            state_q <= DS_DUMP;
            idx_q   <= '0;
            valid_q <= 1'b1;
          end
        end
        DS_DUMP: begin
          // Leaving halt outranks a handshake in the same cycle: abort, no done pulse.
          if (!halted) begin
            state_q <= DS_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
          end else if (dump_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DS_DONE;
              idx_q   <= '0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DS_DONE: begin
          state_q <= DS_HOLD;
        end
        DS_HOLD: begin
          if (!halted) begin
            state_q <= DS_IDLE;
          end
        end
        default: begin
          state_q <= DS_IDLE;
          valid_q <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign dump_valid = valid_q;
  assign dump_idx   = idx_q;
  assign dump_done  = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, NWR write ports with
// highest-index-wins priority, and a handshaked dump of every register when the core halts.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [NRD*AW-1:0]   rd_num,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR*AW-1:0]   wr_num,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_we,
  input  logic                halted,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_done
);

  localparam logic [AW:0] NREGS_L = (AW + 1)'(NREGS);

  logic [XLEN-1:0]              regs_q [NREGS];
  logic [NWR-1:0]               wr_ok;
  logic [NREGS-1:0]             reg_we_d;
  logic [NREGS-1:0][XLEN-1:0]   reg_wd_d;

  // Returns {hit, data} for the highest-indexed qualified write port addressing target.
  function automatic logic [XLEN:0] pick_write(
    input logic [AW-1:0]       target,
    input logic [NWR-1:0]      ok,
    input logic [NWR*AW-1:0]   num,
    input logic [NWR*XLEN-1:0] data
  );
    logic [XLEN:0] res;
    res = '0;
    for (int unsigned w = 0; w < NWR; w++) begin
      if (ok[w] && (num[w*AW +: AW] == target)) begin
        res = {1'b1, data[w*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  // A write port is live only outside halt, in range, and not aimed at a hardwired r0.
  for (genvar w = 0; w < NWR; w++) begin : g_wq
    logic [AW-1:0] wa;
    assign wa       = wr_num[w*AW +: AW];
    assign wr_ok[w] = wr_we[w] && !halted && ({1'b0, wa} < NREGS_L)
                      && !((ZERO_REG != 0) && (wa == '0));
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_wsel
    assign {reg_we_d[r], reg_wd_d[r]} = pick_write(AW'(r), wr_ok, wr_num, wr_data);
  end

  // Register array update; reset clears every entry.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (reg_we_d[r]) begin
          regs_q[r] <= reg_wd_d[r];
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] stored;
    assign ra     = rd_num[p*AW +: AW];
    assign stored = ({1'b0, ra} < NREGS_L) ? regs_q[ra] : '0;
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes r0 and out-of-range targets, so those never forward.
    logic [XLEN:0] fwd;
    assign fwd = pick_write(ra, wr_ok, wr_num, wr_data);
    assign rd_data[p*XLEN +: XLEN] = fwd[XLEN] ? fwd[XLEN-1:0] : stored;
`else
    assign rd_data[p*XLEN +: XLEN] = stored;
`endif
  end

  regfile_dump_fsm #(
    .NREGS (NREGS)
  ) u_dump_fsm (
    .clk        (clk),
    .rst_b      (rst_b),
    .halted     (halted),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_done  (dump_done)
  );

  // Writes are blocked while halted, so the beat data stays stable under backpressure.
  assign dump_data = dump_valid ? regs_q[dump_idx] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against an array model of the register file.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_b;
  logic [NRD*AW-1:0]   rd_num;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR*AW-1:0]   wr_num;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]      wr_we;
  logic                halted;
  logic                dump_valid;
  logic                dump_ready;
  logic [AW-1:0]       dump_idx;
  logic [XLEN-1:0]     dump_data;
  logic                dump_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [XLEN-1:0] mdl [NREGS];

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (1)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .rd_num     (rd_num),
    .rd_data    (rd_data),
    .wr_num     (wr_num),
    .wr_data    (wr_data),
    .wr_we      (wr_we),
    .halted     (halted),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                        input logic we);
    wr_num[w*AW +: AW]      = a;
    wr_data[w*XLEN +: XLEN] = d;
    wr_we[w]                = we;
  endtask

  task automatic rand_writes();
    for (int w = 0; w < NWR; w++)
      set_wr(w, AW'($urandom_range(0, NREGS - 1)), $urandom, 1'($urandom_range(0, 1)));
  endtask

  // Apply the pending writes to the model in port order, so the last port wins.
  task automatic commit();
    if (!halted) begin
      for (int w = 0; w < NWR; w++)
        if (wr_we[w] && wr_num[w*AW +: AW] != 0)
          mdl[wr_num[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
    end
  endtask

  function automatic logic [XLEN-1:0] exp_read(input int unsigned a);
    logic [XLEN-1:0] v;
    v = (a == 0) ? '0 : mdl[a];
`ifdef REGFILE_BYPASS_EN
    if (!halted && a != 0)
      for (int w = 0; w < NWR; w++)
        if (wr_we[w] && wr_num[w*AW +: AW] == a) v = wr_data[w*XLEN +: XLEN];
`endif
    return v;
  endfunction

  task automatic check_reads(input string tag);
    for (int p = 0; p < NRD; p++)
      chk($sformatf("%s_rd%0d", tag, p), rd_data[p*XLEN +: XLEN],
          exp_read(rd_num[p*AW +: AW]));
  endtask

  // Runs one dump; abort_beat >= 0 drops halted while that beat is presented.
  task automatic run_dump(input bit rnd, input int abort_beat);
    int exp_next;
    int cyc;
    bit fin;
    exp_next = 0;
    cyc = 1;
    fin = 1'b0;
    halted = 1'b1;
    dump_ready = 1'b1;
    rand_writes();
    tick();
    while (!fin && cyc <= 6 * NREGS) begin
      if (exp_next == NREGS) begin
        chk("done_pulse", dump_done, 1);
        chk("done_valid_low", dump_valid, 0);
        if (!rnd) chk("done_cycle", cyc, NREGS + 1);
        tick();
        chk("done_width", dump_done, 0);
        fin = 1'b1;
      end else begin
        chk($sformatf("beat%0d_valid", exp_next), dump_valid, 1);
        chk($sformatf("beat%0d_idx", exp_next), dump_idx, exp_next);
        chk($sformatf("beat%0d_data", exp_next), dump_data, mdl[exp_next]);
        chk($sformatf("beat%0d_nodone", exp_next), dump_done, 0);
        if (exp_next == abort_beat) begin
          halted = 1'b0;
          dump_ready = 1'b0;
          wr_we = '0;
          tick();
          chk("abort_valid", dump_valid, 0);
          chk("abort_idx", dump_idx, 0);
          chk("abort_done", dump_done, 0);
          repeat (3) begin
            tick();
            chk("abort_no_done", dump_done, 0);
            chk("abort_stay_idle", dump_valid, 0);
          end
          fin = 1'b1;
        end else begin
          dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (dump_ready) exp_next++;
          rand_writes();
          tick();
          cyc++;
        end
      end
    end
    chk("dump_completed", fin, 1);
    halted = 1'b0;
    dump_ready = 1'b0;
    wr_we = '0;
    tick();
    tick();
  endtask

  initial begin
    rst_b = 1'b0;
    halted = 1'b0;
    dump_ready = 1'b0;
    rd_num = '0;
    wr_num = '0;
    wr_data = '0;
    wr_we = '0;
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    #1;
    chk("rst_rd0", rd_data[0 +: XLEN], 0);
    chk("rst_rd1", rd_data[XLEN +: XLEN], 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_idx", dump_idx, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_done", dump_done, 0);
    #11 rst_b = 1'b1;
    tick();

    // Basic write then read back the next cycle.
    set_wr(0, AW'(5), 32'hDEADBEEF, 1'b1);
    rd_num[0 +: AW] = AW'(5);
    #1;
    chk("t1_same_cycle", rd_data[0 +: XLEN], exp_read(5));
    commit();
    tick();
    set_wr(0, '0, '0, 1'b0);
    #1;
    chk("t1_readback", rd_data[0 +: XLEN], 32'hDEADBEEF);

    // Two ports to one address, then a write to the hardwired zero register.
    set_wr(0, AW'(7), 32'h11, 1'b1);
    set_wr(1, AW'(7), 32'h22, 1'b1);
    commit();
    tick();
    set_wr(0, '0, 32'hFF, 1'b1);
    set_wr(1, '0, '0, 1'b0);
    rd_num = {AW'(0), AW'(7)};
    #1;
    chk("t2_r0_nofwd", rd_data[XLEN +: XLEN], 0);
    commit();
    tick();
    wr_we = '0;
    #1;
    chk("t2_conflict", rd_data[0 +: XLEN], 32'h22);
    chk("t2_r0_zero", rd_data[XLEN +: XLEN], 0);

    // Same-cycle read of a register being written.
    set_wr(1, AW'(3), 32'hABCD, 1'b1);
    rd_num[AW +: AW] = AW'(3);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t3_bypass", rd_data[XLEN +: XLEN], 32'hABCD);
`else
    chk("t3_bypass", rd_data[XLEN +: XLEN], 0);
`endif
    commit();
    tick();
    wr_we = '0;
    #1;
    chk("t3_after", rd_data[XLEN +: XLEN], 32'hABCD);

    // Random traffic, with occasional halt cycles that must block writes.
    for (int c = 0; c < 60; c++) begin
      rand_writes();
      halted = ($urandom_range(0, 7) == 0);
      for (int p = 0; p < NRD; p++)
        rd_num[p*AW +: AW] = (c % 3 == 0) ? wr_num[p*AW +: AW]
                                          : AW'($urandom_range(0, NREGS - 1));
      #1;
      check_reads($sformatf("rnd%0d", c));
      commit();
      tick();
    end
    halted = 1'b0;
    wr_we = '0;
    tick();
    tick();

    // Preload r[i] = 3*i, then full dump with ready held high.
    for (int i = 0; i < NREGS; i += 2) begin
      set_wr(0, AW'(i), XLEN'(i * 3), 1'b1);
      set_wr(1, AW'(i + 1), XLEN'((i + 1) * 3), 1'b1);
      commit();
      tick();
    end
    wr_we = '0;
    run_dump(1'b0, -1);
    rd_num = {AW'(31), AW'(5)};
    #1;
    chk("t4_post_r5", rd_data[0 +: XLEN], 32'd15);
    chk("t4_post_r31", rd_data[XLEN +: XLEN], 32'd93);

    // Dump with random backpressure, then an aborted dump.
    run_dump(1'b1, -1);
    run_dump(1'b0, 10);

    // Reset in the middle of a dump.
    halted = 1'b1;
    dump_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_pre_rst_valid", dump_valid, 1);
    chk("t6_pre_rst_idx", dump_idx, 2);
    #2 rst_b = 1'b0;
    #1;
    chk("t6_rst_valid", dump_valid, 0);
    chk("t6_rst_idx", dump_idx, 0);
    chk("t6_rst_data", dump_data, 0);
    chk("t6_rst_done", dump_done, 0);
    rd_num = {AW'(6), AW'(5)};
    #1;
    chk("t6_rst_r5", rd_data[0 +: XLEN], 0);
    chk("t6_rst_r6", rd_data[XLEN +: XLEN], 0);
    for (int i = 0; i < NREGS; i++) mdl[i] = '0;
    halted = 1'b0;
    dump_ready = 1'b0;
    #3 rst_b = 1'b1;
    tick();
    chk("t6_post_valid", dump_valid, 0);
    set_wr(0, AW'(9), 32'h1234, 1'b1);
    commit();
    tick();
    wr_we = '0;
    rd_num = {AW'(5), AW'(9)};
    #1;
    check_reads("t6_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
